timer_counter: RTL and testbench
================================

Name: timer_counter

Overview:
- Memory-mapped timer peripheral on the device side of the CPU system bridge: responder for bridge writes and reads, source of one hardware interrupt line.
- Two instances sit at windows 0x7F00–0x7F0B and 0x7F10–0x7F1B; the bridge decodes the window and presents word offset, write data and write enable; the device returns read data and raises its interrupt into HWInt.
- Down-counts from a software preset, with one-shot and auto-reload modes.

Parameters:
- WIDTH, 32, data and counter width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- addr  input  2  word offset within the window (PrAddr[3:2]).
- we  input  1  write strobe for this device, one cycle per write.
- wd  input  WIDTH  write data.
- rd  output  WIDTH  read data.
- irq  output  1  interrupt request to the bridge.

Behaviour:
- Register map, indexed by addr:
  - 0 CTRL (rw): bit0 EN, bits2:1 MODE, bit3 IM; bits31:4 read 0, writes to them ignored.
  - 1 PRESET (rw).
  - 2 COUNT (read-only; writes ignored).
  - 3 reserved: reads 0, writes ignored.
- rd: combinational from addr and register contents; no read side effects.
- irq = IM & irq_flag, combinational, no extra latency.
- Reset (reset==0 at a rising edge): CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE; therefore irq=0 and rd=0 for any addr. Reset overrides everything, including a write or a count in the same cycle.
- Writes take effect at the rising edge where we==1.
- Any CTRL write clears irq_flag, except when the counter sets irq_flag on the same edge; the set wins.
- State machine (IDLE, LOAD, CNT, INT), one transition per edge:
  - IDLE: if EN go to LOAD, else stay.
  - LOAD: COUNT<=PRESET, go to CNT unconditionally.
  - CNT, EN==0: hold COUNT and state (pause).
  - CNT, EN==1, COUNT>1: COUNT<=COUNT-1.
  - CNT, EN==1, COUNT<=1: COUNT<=0, irq_flag<=1, go to INT.
  - INT, MODE==0 (one-shot): EN<=0, go to IDLE; irq_flag stays set until a CTRL write.
  - INT, MODE==1 (auto-reload): irq_flag<=0, go to IDLE. If EN is still 1 the timer reloads, so irq_flag is a one-cycle pulse.
  - MODE 2 or 3: stored as written, behave as MODE 0.
- Timing, with write of EN=1 at edge t0 and PRESET=N≥1:
  - LOAD entered at t1.
  - COUNT=N after t2, decrementing one per edge.
  - irq_flag=1 after edge t2+N.
  - Auto-reload period: N+3 cycles.
  - N=0 behaves as N=1.
- Edge cases:
  - PRESET written mid-count: takes effect at the next LOAD only.
  - CTRL write on the same edge that INT clears EN (mode 0): the CPU write wins.
  - EN cleared while in LOAD: LOAD still completes; the counter then pauses in CNT.
  - Timer re-armed in mode 0: software writes CTRL with EN=1, which also clears irq_flag.

Decomposition:
- Package timer_pkg holds:
  - State encoding: IDLE, LOAD, CNT, INT.
  - Register offsets: ADDR_CTRL=0, ADDR_PRESET=1, ADDR_COUNT=2.
  - CTRL bit positions: EN, MODE, IM.
  - MODE constants: MODE_ONESHOT=0, MODE_RELOAD=1.
- Single module, no sub-module: register file, read mux and FSM are small enough to stay flat.

Test Plan:
- Reset: hold reset=0 for 2 cycles after writing all registers → rd=0 at addr 0,1,2; irq=0; state IDLE.
- One-shot: write PRESET=5, then CTRL=0x9 (EN, IM, mode0) at t0 → COUNT reads 5,4,3,2,1 after t2..t6; irq=1 after t7; CTRL reads 0x8; irq stays 1 until a CTRL write of 0x8, then irq=0 the next cycle.
- Auto-reload: PRESET=3, CTRL=0xB → irq pulses high one cycle every 6 cycles, at least 3 consecutive periods; COUNT cycles 3,2,1,0.
- Pause/resume: mid-count at COUNT=4, write CTRL EN=0 for 10 cycles → COUNT holds 4, irq=0; rewrite EN=1 → decrement resumes from 4, with no reload.
- Masking and ignored writes: IM=0 mode 0, PRESET=2 → irq stays 0 while internal expiry still clears EN (CTRL reads 0x0). Write 0x1234 to COUNT and addr 3 → COUNT unchanged, addr 3 reads 0. Write CTRL=0xFFFFFFF1 → reads 0x1.
- Race: in mode 0, issue a CTRL write of 0x9 on the exact edge INT would clear EN → CTRL reads 0x9 and the timer restarts. Separately, a CTRL write coinciding with COUNT reaching 0 → irq_flag=1.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the bus-mapped down-counting timer: FSM encoding,
// register offsets and CTRL field positions.
`timescale 1ns/1ps
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_W       = 4;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counter with one-shot / auto-reload modes and a
// maskable interrupt; register file, read mux and FSM kept flat.
`timescale 1ns/1ps
module timer_counter
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] rd,
  output logic             irq
);

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [WIDTH-1:0]  preset_q, preset_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic              flag_q, flag_d;

  logic en;
  logic reload;
  logic expire;

  assign en     = ctrl_q[CTRL_EN];
  assign reload = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);
  // Expiry also covers a zero preset, so N=0 behaves like N=1.
  assign expire = (state_q == ST_CNT) && en && (count_q <= WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_CNT;
      ST_CNT:  if (expire) state_d = ST_INT;
      ST_INT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    case (state_q)
      ST_LOAD: count_d = preset_q;
      ST_CNT: begin
        if (expire) begin
          count_d = '0;
          flag_d  = 1'b1;
        end else if (en) begin
          count_d = count_q - WIDTH'(1);
        end
      end
      ST_INT: begin
        if (reload) flag_d = 1'b0;
        else        ctrl_d[CTRL_EN] = 1'b0;
      end
      default: ;
    endcase

    // The CPU write is applied last so it overrides the one-shot EN clear;
    // an expiry on the same edge still keeps the flag set.
    if (we) begin
      case (addr)
        ADDR_CTRL: begin
          ctrl_d = wd[CTRL_W-1:0];
          if (!expire) flag_d = 1'b0;
        end
        ADDR_PRESET: preset_d = wd;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    rd = '0;
    case (addr)
      ADDR_CTRL:   rd = WIDTH'(ctrl_q);
      ADDR_PRESET: rd = preset_q;
      ADDR_COUNT:  rd = count_q;
      default:     rd = '0;
    endcase
  end

  assign irq = ctrl_q[CTRL_IM] & flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed and randomized checks of timer_counter against a cycle-level
// reference model plus hand-derived timing expectations.
`timescale 1ns/1ps
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] wd = 32'd0;
  logic [31:0] rd;
  logic        irq;

  int checks = 0;
  int errors = 0;

  timer_counter #(.WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .wd   (wd),
    .rd   (rd),
    .irq  (irq)
  );

  always #10 clk = ~clk;

  // Reference model: software-visible registers plus an activity phase
  // (0 idle, 1 arming, 2 counting, 3 just expired).
  logic [3:0]  m_ctrl = 4'd0;
  logic [31:0] m_preset = 32'd0;
  logic [31:0] m_count = 32'd0;
  bit          m_flag = 1'b0;
  int          m_phase = 0;

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge(input bit w, input logic [1:0] a, input logic [31:0] d);
    logic [3:0]  n_ctrl;
    logic [31:0] n_preset, n_count;
    bit          n_flag, fired;
    int          n_phase;
    if (!reset) begin
      m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 1'b0; m_phase = 0;
      return;
    end
    n_ctrl = m_ctrl; n_preset = m_preset; n_count = m_count;
    n_flag = m_flag; n_phase = m_phase; fired = 1'b0;
    if (m_phase == 0) begin
      if (m_ctrl[0]) n_phase = 1;
    end else if (m_phase == 1) begin
      n_count = m_preset;
      n_phase = 2;
    end else if (m_phase == 2) begin
      if (m_ctrl[0] && m_count > 1) n_count = m_count - 1;
      else if (m_ctrl[0]) begin
        n_count = 0; n_flag = 1'b1; fired = 1'b1; n_phase = 3;
      end
    end else begin
      n_phase = 0;
      if (m_ctrl[2:1] == 2'd1) n_flag = 1'b0;
      else n_ctrl[0] = 1'b0;
    end
    if (w && a == 2'd0) begin
      n_ctrl = d[3:0];
      if (!fired) n_flag = 1'b0;
    end
    if (w && a == 2'd1) n_preset = d;
    m_ctrl = n_ctrl; m_preset = n_preset; m_count = n_count;
    m_flag = n_flag; m_phase = n_phase;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic peek(input logic [1:0] a, input string tag, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rd, exp);
  endtask

  task automatic check_irq(input string tag, input bit exp);
    check(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  task automatic model_check();
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      check($sformatf("model rd[%0d]", a), rd, m_read(2'(a)));
    end
    check_irq("model irq", m_ctrl[3] & m_flag);
  endtask

  task automatic tick(input bit w = 1'b0, input logic [1:0] a = 2'd0, input logic [31:0] d = 32'd0);
    we = w; addr = a; wd = d;
    if (w) $display("write addr=%0d data=0x%08h t=%0t", a, d, $time);
    @(posedge clk);
    model_edge(w, a, d);
    #1;
    we = 1'b0; wd = 32'd0;
    model_check();
  endtask

  task automatic restart();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int pulses;
    logic [1:0]  ra;
    logic [31:0] rdat;

    tick(); tick();
    reset = 1'b1;

    // Reset clears everything that was written before it
    tick(1, 2'd0, 32'hF);
    tick(1, 2'd1, 32'd7);
    reset = 1'b0;
    tick(); tick();
    peek(2'd0, "reset ctrl", 32'd0);
    peek(2'd1, "reset preset", 32'd0);
    peek(2'd2, "reset count", 32'd0);
    check_irq("reset irq", 1'b0);
    reset = 1'b1;
    tick(1, 2'd1, 32'd5); tick(); tick();
    peek(2'd2, "idle after reset", 32'd0);

    // One-shot, N=5
    restart();
    tick(1, 2'd1, 32'd5);
    tick(1, 2'd0, 32'h9);
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      peek(2'd2, "oneshot count", 32'(5 - k));
    end
    tick();
    check_irq("oneshot irq set", 1'b1);
    peek(2'd2, "oneshot count end", 32'd0);
    tick();
    peek(2'd0, "oneshot ctrl", 32'h8);
    repeat (3) tick();
    check_irq("oneshot irq held", 1'b1);
    tick(1, 2'd0, 32'h8);
    check_irq("oneshot irq cleared", 1'b0);

    // Auto-reload, N=3: period 6, first pulse 5 edges after the enabling write
    restart();
    tick(1, 2'd1, 32'd3);
    tick(1, 2'd0, 32'hB);
    pulses = 0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      check_irq("reload irq", (k >= 5) && ((k - 5) % 6 == 0));
      if (irq) pulses++;
      if (k >= 2) peek(2'd2, "reload count", ((k - 2) % 6 <= 3) ? 32'(3 - (k - 2) % 6) : 32'd0);
    end
    check("reload pulses", 32'(pulses), 32'd4);
    tick(1, 2'd0, 32'd0);

    // Pause at 4, resume without reload
    restart();
    tick(1, 2'd1, 32'd8);
    tick(1, 2'd0, 32'h9);
    repeat (5) tick();
    tick(1, 2'd0, 32'h8);
    peek(2'd2, "pause count", 32'd4);
    repeat (10) tick();
    peek(2'd2, "pause hold", 32'd4);
    check_irq("pause irq", 1'b0);
    tick(1, 2'd0, 32'h9);
    peek(2'd2, "resume first", 32'd4);
    for (int j = 1; j <= 3; j++) begin
      tick();
      peek(2'd2, "resume count", 32'(4 - j));
    end
    tick();
    peek(2'd2, "resume expire", 32'd0);
    check_irq("resume irq", 1'b1);

    // Masked expiry and ignored writes
    restart();
    tick(1, 2'd1, 32'd2);
    tick(1, 2'd0, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_irq("masked irq", 1'b0);
    end
    peek(2'd0, "masked ctrl", 32'd0);
    tick(1, 2'd2, 32'h1234);
    peek(2'd2, "count write ignored", 32'd0);
    tick(1, 2'd3, 32'h1234);
    peek(2'd3, "reserved reads 0", 32'd0);
    tick(1, 2'd0, 32'hFFFF_FFF1);
    peek(2'd0, "ctrl upper bits", 32'h1);
    peek(2'd1, "preset kept", 32'd2);

    // Races: CPU write vs one-shot EN clear, and vs expiry
    restart();
    tick(1, 2'd1, 32'd2);
    tick(1, 2'd0, 32'h9);
    repeat (4) tick();
    check_irq("race irq set", 1'b1);
    tick(1, 2'd0, 32'h9);
    peek(2'd0, "race ctrl wins", 32'h9);
    check_irq("race irq cleared", 1'b0);
    tick(); tick();
    peek(2'd2, "race restart", 32'd2);
    tick();
    tick(1, 2'd0, 32'h9);
    check_irq("race set wins", 1'b1);
    peek(2'd2, "race count zero", 32'd0);

    // N=0 behaves like N=1
    restart();
    tick(1, 2'd1, 32'd0);
    tick(1, 2'd0, 32'h9);
    tick(); tick();
    check_irq("n0 before", 1'b0);
    tick();
    check_irq("n0 expire", 1'b1);

    // Randomized soak against the model
    restart();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ra = 2'($urandom_range(0, 3));
        if (ra == 2'd1)      rdat = 32'($urandom_range(0, 6));
        else if (ra == 2'd0) rdat = 32'($urandom_range(0, 15));
        else                 rdat = $urandom;
        tick(1'b1, ra, rdat);
      end else begin
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
